// File: rtl/ctr_pkg.sv
// Shared definitions for the gated-counter window averager.
// Holds default widths, the window FSM encoding and the log2 window clamp.
// No timing of its own; used by ctr_window_averager and ctr_round_shift.
package ctr_pkg;

  localparam int unsigned W_CTR_DEF   = 32;
  localparam int unsigned MAX_LOG_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } ctr_state_e;

  // Effective log2 window length: requests beyond the supported maximum
  // saturate rather than wrap.
  function automatic int unsigned clamp_log(input int unsigned log_n,
                                            input int unsigned max_log = MAX_LOG_DEF);
    return (log_n > max_log) ? max_log : log_n;
  endfunction

endpackage

// File: rtl/ctr_round_shift.sv
// Rounding divider: registers a closed window sum, then presents sum / 2^log rounded half up.
// Latency: avg_o/vld_o valid the cycle after vld_i (one register, combinational shift after it).
// No backpressure: accepts a sum every cycle; kill_i drops the sum presented that cycle.
// Ports: sum_i/log_i/vld_i closed-window sum in, kill_i restart, avg_o/vld_o rounded mean out.
module ctr_round_shift
  import ctr_pkg::*;
#(
  parameter int unsigned W_CTR   = W_CTR_DEF,
  parameter int unsigned MAX_LOG = MAX_LOG_DEF,
  parameter int unsigned LW      = $clog2(MAX_LOG + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W_CTR+MAX_LOG-1:0] sum_i,
  input  logic [LW-1:0]            log_i,
  input  logic                     vld_i,
  input  logic                     kill_i,
  output logic [W_CTR-1:0]         avg_o,
  output logic                     vld_o
);

  localparam int unsigned SW = W_CTR + MAX_LOG;
  localparam int unsigned RW = SW + 1;

  logic [SW-1:0] sum_q;
  logic [LW-1:0] log_q;
  logic          vld_q;
  logic [RW-1:0] rnd;
  logic [RW-1:0] tot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      log_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_i & ~kill_i;
      if (vld_i) begin
        sum_q <= sum_i;
        log_q <= log_i;
      end
    end
  end

  // Half an LSB of the result is added before the shift; N=1 needs no rounding.
  // The mean of W_CTR-bit samples always fits back into W_CTR bits, so the
  // truncating cast never discards a set bit.
  always_comb begin
    rnd   = (log_q == '0) ? '0 : (RW'(1) << (log_q - 1'b1));
    tot   = {1'b0, sum_q} + rnd;
    avg_o = W_CTR'(tot >> log_q);
    vld_o = vld_q;
  end

endmodule

// File: rtl/ctr_window_averager.sv
// Averages 2^log_n consecutive counter samples and emits mean and signed error vs setpoint.
// Latency: res_vld two cycles after the window-closing cnt_vld; one sample per cycle sustained.
// No backpressure: strobes are never stalled; clr discards the open window and in-flight results.
// Ports: cnt_in/cnt_vld samples, log_n/setpoint config, clr restart; avg/err/res_vld/n_win results.
module ctr_window_averager
  import ctr_pkg::*;
#(
  parameter int unsigned W_CTR   = W_CTR_DEF,
  parameter int unsigned MAX_LOG = MAX_LOG_DEF,
  parameter int unsigned W_LOG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W_CTR-1:0] cnt_in,
  input  logic             cnt_vld,
  input  logic [W_LOG-1:0] log_n,
  input  logic [W_CTR-1:0] setpoint,
  input  logic             clr,
  output logic [W_CTR-1:0] avg,
  output logic [W_CTR:0]   err,
  output logic             res_vld,
  output logic [W_CTR-1:0] n_win
);

  localparam int unsigned SW = W_CTR + MAX_LOG;
  localparam int unsigned FW = MAX_LOG + 1;
  localparam int unsigned LW = $clog2(MAX_LOG + 1);

  ctr_state_e state_q, state_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [LW-1:0] log_q, log_d;

  logic [LW-1:0] log_in, log_use;
  logic [SW-1:0] base_acc, sum_new;
  logic [FW-1:0] base_fill, fill_new;
  logic          hit, close;

  logic [W_CTR-1:0] p1_avg;
  logic             p1_vld;

  logic [W_CTR-1:0] avg_q, avg_d;
  logic [W_CTR:0]   err_q, err_d;
  logic             res_vld_q, res_vld_d;
  logic [W_CTR-1:0] n_win_q, n_win_d;

  // An idle channel behaves like an empty open window, so opening and
  // accumulating share one adder and one completion compare (covers N=1).
  always_comb begin
    log_in    = LW'(clamp_log(32'(log_n), MAX_LOG));
    base_acc  = (state_q == ST_FILL) ? acc_q  : '0;
    base_fill = (state_q == ST_FILL) ? fill_q : '0;
    log_use   = (state_q == ST_FILL) ? log_q  : log_in;
    sum_new   = base_acc + SW'(cnt_in);
    fill_new  = base_fill + FW'(1);
    hit       = cnt_vld && (fill_new == (FW'(1) << log_use));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr)          state_d = ST_IDLE;
    else if (cnt_vld) state_d = hit ? ST_IDLE : ST_FILL;
  end

  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    log_d  = log_q;
    close  = 1'b0;
    if (clr) begin
      acc_d  = '0;
      fill_d = '0;
    end else if (cnt_vld) begin
      log_d = log_use;
      if (hit) begin
        // Window hands its sum to the pipeline and frees the accumulator now,
        // so a strobe in the very next cycle opens a fresh window.
        acc_d  = '0;
        fill_d = '0;
        close  = 1'b1;
      end else begin
        acc_d  = sum_new;
        fill_d = fill_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      fill_q <= '0;
      log_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
      log_q  <= log_d;
    end
  end

  ctr_round_shift #(
    .W_CTR  (W_CTR),
    .MAX_LOG(MAX_LOG),
    .LW     (LW)
  ) u_round (
    .clk   (clk),
    .rst_n (rst_n),
    .sum_i (sum_new),
    .log_i (log_use),
    .vld_i (close),
    .kill_i(clr),
    .avg_o (p1_avg),
    .vld_o (p1_vld)
  );

  // Result stage; setpoint is taken here so a change applies to the next result.
  always_comb begin
    res_vld_d = p1_vld && !clr;
    avg_d     = avg_q;
    err_d     = err_q;
    n_win_d   = n_win_q;
    if (res_vld_d) begin
      avg_d   = p1_avg;
      err_d   = {1'b0, p1_avg} - {1'b0, setpoint};
      n_win_d = n_win_q + W_CTR'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_q     <= '0;
      err_q     <= '0;
      res_vld_q <= 1'b0;
      n_win_q   <= '0;
    end else begin
      avg_q     <= avg_d;
      err_q     <= err_d;
      res_vld_q <= res_vld_d;
      n_win_q   <= n_win_d;
    end
  end

  assign avg     = avg_q;
  assign err     = err_q;
  assign res_vld = res_vld_q;
  assign n_win   = n_win_q;

endmodule

// File: tb/tb_ctr_window_averager.sv
// Directed scoreboard bench for ctr_window_averager.
// Stimulus pushes expected results with their due cycle; a negedge monitor pops and compares.
module tb_ctr_window_averager;

  logic        clk;
  logic        rst_n;
  logic [31:0] cnt_in;
  logic        cnt_vld;
  logic [3:0]  log_n;
  logic [31:0] setpoint;
  logic        clr;
  logic [31:0] avg;
  logic [32:0] err;
  logic        res_vld;
  logic [31:0] n_win;

  typedef struct {
    logic [31:0] avg;
    logic [32:0] err;
    logic [31:0] nwin;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   nvec  = 0;
  int   nmiss = 0;

  ctr_window_averager #(.W_CTR(32), .MAX_LOG(8), .W_LOG(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_in  (cnt_in),
    .cnt_vld (cnt_vld),
    .log_n   (log_n),
    .setpoint(setpoint),
    .clr     (clr),
    .avg     (avg),
    .err     (err),
    .res_vld (res_vld),
    .n_win   (n_win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus, changed 1ns after the edge so the DUT sees it at the next edge.
  task automatic drive(input logic v, input logic [31:0] d, input logic c);
    @(posedge clk);
    #1;
    cnt_vld = v;
    cnt_in  = d;
    clr     = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0);
  endtask

  // Called right after driving the closing strobe: result due two cycles later.
  task automatic expect_res(input logic [31:0] a, input logic [32:0] e, input logic [31:0] w);
    exp_t x;
    x.avg  = a;
    x.err  = e;
    x.nwin = w;
    x.cyc  = cyc + 2;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (res_vld === 1'b1) begin
        if (sb.size() == 0) begin
          nvec++;
          nmiss++;
          $display("FAIL unexpected_res_vld: got res_vld=1 avg=0x%0h at cycle %0d want no result", avg, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("avg",     64'(avg),   64'(e.avg));
          chk("err",     64'(err),   64'(e.err));
          chk("n_win",   64'(n_win), 64'(e.nwin));
          chk("latency", 64'(cyc),   64'(e.cyc));
        end
      end else if (sb.size() != 0 && cyc >= sb[0].cyc) begin
        nvec++;
        nmiss++;
        $display("FAIL missing_res_vld: got no res_vld by cycle %0d want avg=0x%0h", cyc, sb[0].avg);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    cnt_in   = '0;
    cnt_vld  = 1'b0;
    log_n    = '0;
    setpoint = '0;
    clr      = 1'b0;

    // Reset state, with a strobe held active to show it is ignored.
    cnt_vld = 1'b1;
    cnt_in  = 32'd55;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_avg",     64'(avg),     64'd0);
    chk("rst_err",     64'(err),     64'd0);
    chk("rst_res_vld", 64'(res_vld), 64'd0);
    chk("rst_n_win",   64'(n_win),   64'd0);
    cnt_vld = 1'b0;
    cnt_in  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // N=4, 101.5 rounds up to 102.
    log_n = 4'd2; setpoint = 32'd100;
    drive(1'b1, 32'd100, 1'b0);
    drive(1'b1, 32'd101, 1'b0);
    drive(1'b1, 32'd102, 1'b0);
    drive(1'b1, 32'd103, 1'b0);
    expect_res(32'd102, 33'd2, 32'd1);
    idle(5);

    // N=1 back-to-back: results on consecutive cycles, negative then positive error.
    log_n = 4'd0; setpoint = 32'd50;
    drive(1'b1, 32'd40, 1'b0);
    expect_res(32'd40, 33'h1_FFFF_FFF6, 32'd2);
    drive(1'b1, 32'd60, 1'b0);
    expect_res(32'd60, 33'h0_0000_000A, 32'd3);
    idle(5);

    // Full-scale samples: mean must not wrap.
    log_n = 4'd3; setpoint = 32'd0;
    for (int i = 0; i < 8; i++) drive(1'b1, 32'hFFFF_FFFF, 1'b0);
    expect_res(32'hFFFF_FFFF, 33'h0_FFFF_FFFF, 32'd4);
    idle(5);

    // clr between windows discards the partial window.
    log_n = 4'd2; setpoint = 32'd0;
    drive(1'b1, 32'd5, 1'b0);
    drive(1'b1, 32'd5, 1'b0);
    drive(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'd10, 1'b0);
    expect_res(32'd10, 33'd10, 32'd5);
    idle(5);

    // clr coincident with a strobe drops that sample too.
    drive(1'b1, 32'd99, 1'b0);
    drive(1'b1, 32'd99, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'd20, 1'b0);
    expect_res(32'd20, 33'd20, 32'd6);
    idle(5);

    // clr the cycle after a window closes kills the in-flight result.
    log_n = 4'd0;
    drive(1'b1, 32'd77, 1'b0);
    drive(1'b0, 32'd0, 1'b1);
    idle(6);
    chk("clr_hold_avg",   64'(avg),   64'd20);
    chk("clr_hold_n_win", 64'(n_win), 64'd6);

    // log_n change mid-window applies only from the next window (7.5 rounds to 8).
    log_n = 4'd2;
    drive(1'b1, 32'd4, 1'b0);
    drive(1'b1, 32'd4, 1'b0);
    log_n = 4'd1;
    drive(1'b1, 32'd4, 1'b0);
    drive(1'b1, 32'd4, 1'b0);
    expect_res(32'd4, 33'd4, 32'd7);
    drive(1'b1, 32'd6, 1'b0);
    drive(1'b1, 32'd9, 1'b0);
    expect_res(32'd8, 33'd8, 32'd8);
    idle(5);

    // log_n beyond the maximum clamps to 256 samples.
    log_n = 4'd15; setpoint = 32'd1;
    for (int i = 0; i < 256; i++) drive(1'b1, 32'd3, 1'b0);
    expect_res(32'd3, 33'd2, 32'd9);
    idle(5);

    // Asynchronous reset in the middle of an open window.
    for (int i = 0; i < 10; i++) drive(1'b1, 32'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_avg",     64'(avg),     64'd0);
    chk("arst_err",     64'(err),     64'd0);
    chk("arst_res_vld", 64'(res_vld), 64'd0);
    chk("arst_n_win",   64'(n_win),   64'd0);
    repeat (3) @(posedge clk);
    #1;
    cnt_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);

    // Fresh operation after reset.
    log_n = 4'd1; setpoint = 32'd0;
    drive(1'b1, 32'd2, 1'b0);
    drive(1'b1, 32'd4, 1'b0);
    expect_res(32'd3, 33'd3, 32'd1);
    idle(6);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
